// File: rtl/id_pkg.sv
// Shared encodings for the ARM decode stage: instruction fields, ALU commands,
// condition codes, status bit positions and the EX control bundle.
package id_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r;
    logic       mem_w;
    logic       wb_en;
    logic       s;
    logic       b;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] status);
    logic n, z, c, v;
    n = status[ST_N];
    z = status[ST_Z];
    c = status[ST_C];
    v = status[ST_V];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      COND_NV: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two combinational read ports with same-cycle
// write-back bypass; out-of-range indices read as zero and are never written.
module id_regfile #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [3:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] regs_d [REG_CNT];

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < REG_CNT; i++) begin
      if (wr_en && wr_addr == 4'(i)) regs_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Only indices that exist can match, so a bypass never leaks past REG_CNT.
  always_comb begin
    rd_data_a = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      if (rd_addr_a == 4'(i))
        rd_data_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : regs_q[i];
    end
  end

  always_comb begin
    rd_data_b = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      if (rd_addr_b == 4'(i))
        rd_data_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : regs_q[i];
    end
  end

endmodule

// File: rtl/id_stage_reg.sv
// ARM decode stage with register file, condition check, RAW hazard detection
// and its own ID/EX pipeline register.
module id_stage_reg
  import id_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_CNT    = 16,
  parameter bit FORWARD_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instr,
  input  logic [3:0]        status,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              exe_wb_en,
  input  logic [3:0]        exe_dest,
  input  logic              exe_mem_r,
  input  logic              mem_wb_en,
  input  logic [3:0]        mem_dest,
  output logic              hazard,
  output logic [31:0]       pc_out,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm24,
  output logic [3:0]        dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic [3:0]        exe_cmd,
  output logic              mem_r,
  output logic              mem_w,
  output logic              wb_en_out,
  output logic              s_out,
  output logic              b_out
);

  logic [1:0]        mode;
  logic [3:0]        opcode, rn_idx, rd_idx, src2_idx;
  logic              i_bit, l_bit, is_str, cond_ok;
  logic              uses_rn, uses_src2;
  logic              ex_hit_rn, ex_hit_src2, mem_hit_rn, mem_hit_src2;
  logic [DATA_W-1:0] rn_val, rm_val;
  ctrl_t             ctrl_dec, ctrl_out;

  assign mode     = instr[27:26];
  assign i_bit    = instr[25];
  assign opcode   = instr[24:21];
  assign l_bit    = instr[20];
  assign rn_idx   = instr[19:16];
  assign rd_idx   = instr[15:12];
  assign is_str   = (mode == MODE_MEM) && !l_bit;
  // Stores read the data register Rd through the second port.
  assign src2_idx = is_str ? rd_idx : instr[3:0];
  assign cond_ok  = cond_pass(instr[31:28], status);

  id_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wb_en),
    .wr_addr   (wb_dest),
    .wr_data   (wb_value),
    .rd_addr_a (rn_idx),
    .rd_data_a (rn_val),
    .rd_addr_b (src2_idx),
    .rd_data_b (rm_val)
  );

  always_comb begin
    ctrl_dec = '0;
    case (mode)
      MODE_DP: begin
        ctrl_dec.s     = l_bit;
        ctrl_dec.wb_en = 1'b1;
        case (opcode)
          OP_MOV: ctrl_dec.exe_cmd = EXE_MOV;
          OP_MVN: ctrl_dec.exe_cmd = EXE_MVN;
          OP_ADD: ctrl_dec.exe_cmd = EXE_ADD;
          OP_ADC: ctrl_dec.exe_cmd = EXE_ADC;
          OP_SUB: ctrl_dec.exe_cmd = EXE_SUB;
          OP_SBC: ctrl_dec.exe_cmd = EXE_SBC;
          OP_AND: ctrl_dec.exe_cmd = EXE_AND;
          OP_ORR: ctrl_dec.exe_cmd = EXE_ORR;
          OP_EOR: ctrl_dec.exe_cmd = EXE_EOR;
          OP_CMP: begin
            ctrl_dec.exe_cmd = EXE_SUB;
            ctrl_dec.wb_en   = 1'b0;
          end
          OP_TST: begin
            ctrl_dec.exe_cmd = EXE_AND;
            ctrl_dec.wb_en   = 1'b0;
          end
          default: ctrl_dec.wb_en = 1'b0;
        endcase
      end
      MODE_MEM: begin
        ctrl_dec.exe_cmd = EXE_ADD;
        ctrl_dec.mem_r   = l_bit;
        ctrl_dec.mem_w   = !l_bit;
        ctrl_dec.wb_en   = l_bit;
      end
      MODE_BR: begin
        ctrl_dec.exe_cmd = EXE_NOP;
        ctrl_dec.b       = 1'b1;
      end
      default: ctrl_dec = '0;
    endcase
  end

  // Hazard ignores the condition outcome so a squashed op never races a producer.
  always_comb begin
    uses_rn      = !(((mode == MODE_DP) && (opcode == OP_MOV || opcode == OP_MVN)) ||
                     (mode == MODE_BR));
    uses_src2    = ((mode == MODE_DP) && !i_bit) || is_str;
    ex_hit_rn    = exe_wb_en && (exe_dest == rn_idx);
    ex_hit_src2  = exe_wb_en && (exe_dest == src2_idx);
    mem_hit_rn   = mem_wb_en && (mem_dest == rn_idx);
    mem_hit_src2 = mem_wb_en && (mem_dest == src2_idx);
    hazard       = 1'b0;
    if (FORWARD_EN)
      hazard = exe_mem_r && ((uses_rn && ex_hit_rn) || (uses_src2 && ex_hit_src2));
    else
      hazard = (uses_rn && (ex_hit_rn || mem_hit_rn)) ||
               (uses_src2 && (ex_hit_src2 || mem_hit_src2));
  end

  logic [31:0]       pc_q, pc_d;
  logic [DATA_W-1:0] val_rn_q, val_rn_d, val_rm_q, val_rm_d;
  logic              imm_q, imm_d;
  logic [11:0]       shift_q, shift_d;
  logic [23:0]       simm_q, simm_d;
  logic [3:0]        dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Priority: flush bubble, then freeze hold, then hazard bubble, then load.
  always_comb begin
    pc_d     = pc_q;
    val_rn_d = val_rn_q;
    val_rm_d = val_rm_q;
    imm_d    = imm_q;
    shift_d  = shift_q;
    simm_d   = simm_q;
    dest_d   = dest_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    ctrl_d   = ctrl_q;
    if (flush || (!freeze && hazard)) begin
      pc_d     = '0;
      val_rn_d = '0;
      val_rm_d = '0;
      imm_d    = 1'b0;
      shift_d  = '0;
      simm_d   = '0;
      dest_d   = '0;
      src1_d   = '0;
      src2_d   = '0;
      ctrl_d   = '0;
    end else if (!freeze) begin
      pc_d     = pc_in;
      val_rn_d = rn_val;
      val_rm_d = rm_val;
      imm_d    = i_bit;
      shift_d  = instr[11:0];
      simm_d   = instr[23:0];
      dest_d   = rd_idx;
      src1_d   = rn_idx;
      src2_d   = src2_idx;
      ctrl_d   = cond_ok ? ctrl_dec : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      val_rn_q <= '0;
      val_rm_q <= '0;
      imm_q    <= 1'b0;
      shift_q  <= '0;
      simm_q   <= '0;
      dest_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      ctrl_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      val_rn_q <= val_rn_d;
      val_rm_q <= val_rm_d;
      imm_q    <= imm_d;
      shift_q  <= shift_d;
      simm_q   <= simm_d;
      dest_q   <= dest_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign ctrl_out      = ctrl_t'(ctrl_q);
  assign pc_out        = pc_q;
  assign val_rn        = val_rn_q;
  assign val_rm        = val_rm_q;
  assign imm           = imm_q;
  assign shift_operand = shift_q;
  assign signed_imm24  = simm_q;
  assign dest          = dest_q;
  assign src1          = src1_q;
  assign src2          = src2_q;
  assign exe_cmd       = ctrl_out.exe_cmd;
  assign mem_r         = ctrl_out.mem_r;
  assign mem_w         = ctrl_out.mem_w;
  assign wb_en_out     = ctrl_out.wb_en;
  assign s_out         = ctrl_out.s;
  assign b_out         = ctrl_out.b;

endmodule

// File: doc/id_stage_reg.md
Name: id_stage_reg

Overview:
- Parametrised ARM instruction-decode stage with its own ID/EX pipeline register.
- Holds the architectural register file, with write-back bypass on reads.
- Evaluates the condition field against the status flags and generates EX control signals.
- Detects RAW hazards against EX/MEM destinations; sits between IF/ID and EX.

Parameters:
- DATA_W, 32, register/operand width.
- REG_CNT, 16, number of architectural registers (≤16; addresses are 4-bit instruction fields).
- FORWARD_EN, 0, 1 = a forwarding unit exists downstream, so stall only on load-use.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  hold ID/EX register (global stall).
- flush  in  1  replace next ID/EX contents with bubble (branch taken).
- pc_in  in  32  PC+4 of the decoding instruction.
- instr  in  32  instruction word.
- status  in  4  {N,Z,C,V}.
- wb_en  in  1  write-back enable.
- wb_dest  in  4  write-back register.
- wb_value  in  DATA_W  write-back data.
- exe_wb_en  in  1  EX-stage write enable.
- exe_dest  in  4  EX-stage destination register.
- exe_mem_r  in  1  EX-stage instruction is a load.
- mem_wb_en  in  1  MEM-stage write enable.
- mem_dest  in  4  MEM-stage destination register.
- hazard  out  1  combinational stall request to IF and IF/ID.
- pc_out  out  32  registered PC.
- val_rn  out  DATA_W  registered Rn value.
- val_rm  out  DATA_W  registered Rm value (Rd for STR).
- imm  out  1  registered I bit.
- shift_operand  out  12  registered instr[11:0].
- signed_imm24  out  24  registered instr[23:0].
- dest  out  4  registered Rd.
- src1  out  4  registered Rn index.
- src2  out  4  registered Rm/Rd index.
- exe_cmd  out  4  ALU command.
- mem_r  out  1  load.
- mem_w  out  1  store.
- wb_en_out  out  1  write-back enable.
- s_out  out  1  update status.
- b_out  out  1  branch.

Behaviour:
- Reset: all registered outputs 0; all registers 0. hazard stays combinational.
- Decode:
  - mode = instr[27:26]: 00 data-processing, 01 memory (L = instr[20]), 10 branch; 11 produces zero control.
  - opcode = instr[24:21]. exe_cmd map: MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110, LDR/STR→0010.
  - CMP and TST set wb_en = 0. LDR: mem_r = 1, wb_en = 1. STR: mem_w = 1.
  - s = instr[20] for data-processing, 0 otherwise. Branch: b = 1, exe_cmd 0000.
- Register file:
  - Two combinational read ports; src1 = Rn, src2 = STR ? Rd : Rm.
  - Write at rising clk when wb_en and wb_dest < REG_CNT.
  - Same-cycle read of wb_dest while wb_en = 1 returns wb_value.
  - Read index ≥ REG_CNT returns 0.
- Condition check on instr[31:28]: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE per ARM; 1110 = always; 1111 = never.
  - Condition fail zeroes the control fields only (exe_cmd, mem_r, mem_w, wb_en_out, s_out, b_out); data fields load normally.
- Hazard, combinational:
  - uses_rn is 0 only for MOV, MVN and branch.
  - uses_src2 = (data-processing with I = 0) or STR.
  - match(x) = (x == exe_dest && exe_wb_en) or (x == mem_dest && mem_wb_en).
  - FORWARD_EN = 0: hazard = (uses_rn && match(src1)) or (uses_src2 && match(src2)).
  - FORWARD_EN = 1: only the EX term applies, additionally gated by exe_mem_r.
  - Hazard is evaluated independently of the condition outcome.
- ID/EX update priority per rising edge: rst > flush (bubble) > freeze (hold) > hazard (bubble) > load.
  - Bubble = every registered output 0.
  - Latency: one cycle from instr to registered outputs.
- Reset asserted mid-stall clears everything immediately, without waiting for a clock edge.

Decomposition:
- Package id_pkg holds:
  - mode, opcode and exe_cmd localparams;
  - condition codes;
  - status bit positions;
  - the bubble/control struct width constant.
- One sub-module, id_regfile: parametrised DATA_W/REG_CNT storage with bypass.
- Control decode, condition check and hazard logic stay inline as combinational always blocks.

Test Plan:
- MOV R1,#5 (0xE3A01005), status 0 → next cycle: exe_cmd 0001, wb_en_out 1, imm 1, dest 1, shift_operand 0x005, hazard 0.
- ADD R2,R1,R1 (0xE0812001) with exe_dest = 1, exe_wb_en = 1:
  - FORWARD_EN = 0 → hazard 1; next cycle all outputs 0.
  - FORWARD_EN = 1 with exe_mem_r = 0 → hazard 0 and exe_cmd 0010 loaded.
- ADDEQ 0x00812001 with Z = 0 → exe_cmd 0, wb_en_out 0, src1 1, dest 2. Same instruction with Z = 1 → exe_cmd 0010, wb_en_out 1.
- wb_en = 1, wb_dest = 3, wb_value = 0xDEADBEEF in the same cycle as decoding ADD R0,R3,R3 → val_rn = val_rm = 0xDEADBEEF next cycle; R3 keeps that value afterwards.
- B +4 (0xEA000004) → b_out 1, signed_imm24 0x000004.
  - flush and hazard asserted together → bubble.
  - freeze → outputs hold for 3 cycles, then load.
- rst pulse between clock edges during a freeze → all outputs 0 immediately; registers read 0.
